// File: rtl/f2c_chunk_arbiter_if.sv
// Handshake bundle between the FPGA->CPU stream sources, the chunk arbiter
// and the transceiver f2c port.
interface f2c_chunk_arbiter_if #(
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC-1:0][63:0] srcData_in;
  logic [NUM_SRC-1:0]       srcValid_in;
  logic [NUM_SRC-1:0]       srcReady_out;
  logic [63:0]              f2cData_out;
  logic                     f2cValid_out;
  logic                     f2cReady_in;

  // Sources and transceiver side
  modport master (
    output srcData_in, srcValid_in, f2cReady_in,
    input  srcReady_out, f2cData_out, f2cValid_out
  );

  // Arbiter side
  modport slave (
    input  srcData_in, srcValid_in, f2cReady_in,
    output srcReady_out, f2cData_out, f2cValid_out
  );
endinterface

// File: rtl/f2c_chunk_arbiter.sv
// Round-robin arbiter that hands the f2c DMA port to one source for exactly
// CHUNK_QWS beats at a time, with a combinational data/valid/ready mux.
module f2c_chunk_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int CHUNK_QWS = 16,
  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int QW = $clog2(CHUNK_QWS)
) (
  input  logic                     pcieClk_in,
  input  logic                     pcieRstN_in,
  input  logic                     f2cReset_in,
  f2c_chunk_arbiter_if.slave       bus,
  output logic [GW-1:0]            grant_out,
  output logic                     busy_out,
  output logic [NUM_SRC-1:0][15:0] chunkCount_out
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                   state, nextState;
  logic [GW-1:0]            grant, nextGrant, arbIdx, candIdx;
  logic [QW-1:0]            qwCount, nextQwCount;
  logic [NUM_SRC-1:0][15:0] chunkCountReg, nextChunkCount;
  logic                     arbFound;

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      state         <= S_IDLE;
      grant         <= GW'(NUM_SRC - 1);
      qwCount       <= '0;
      chunkCountReg <= '0;
    end else if (f2cReset_in) begin
      state         <= S_IDLE;
      grant         <= GW'(NUM_SRC - 1);
      qwCount       <= '0;
      chunkCountReg <= '0;
    end else begin
      state         <= nextState;
      grant         <= nextGrant;
      qwCount       <= nextQwCount;
      chunkCountReg <= nextChunkCount;
    end
  end

  // First requester strictly after the current grant, wrapping modulo NUM_SRC;
  // the current grant itself is the last candidate so a lone source is re-granted.
  always_comb begin
    arbIdx   = grant;
    candIdx  = grant;
    arbFound = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      candIdx = GW'((int'(grant) + k) % NUM_SRC);
      if (!arbFound && bus.srcValid_in[candIdx]) begin
        arbIdx   = candIdx;
        arbFound = 1'b1;
      end
    end
  end

  always_comb begin
    nextState        = state;
    nextGrant        = grant;
    nextQwCount      = qwCount;
    nextChunkCount   = chunkCountReg;
    bus.srcReady_out = '0;
    bus.f2cData_out  = '0;
    bus.f2cValid_out = 1'b0;
    busy_out         = 1'b0;
    case (state)
      S_IDLE: begin
        if (arbFound) begin
          nextGrant   = arbIdx;
          nextQwCount = QW'(CHUNK_QWS - 1);
          nextState   = S_BUSY;
        end
      end
      S_BUSY: begin
        busy_out                = 1'b1;
        bus.f2cData_out         = bus.srcData_in[grant];
        bus.f2cValid_out        = bus.srcValid_in[grant];
        bus.srcReady_out[grant] = bus.f2cReady_in;
        // The last beat closes the chunk without re-arbitrating, forcing one idle cycle
        if (bus.srcValid_in[grant] && bus.f2cReady_in) begin
          if (qwCount == '0) begin
            nextChunkCount[grant] = chunkCountReg[grant] + 16'd1;
            nextState             = S_IDLE;
          end else begin
            nextQwCount = qwCount - QW'(1);
          end
        end
      end
      default: nextState = S_IDLE;
    endcase
  end

  assign grant_out      = grant;
  assign chunkCount_out = chunkCountReg;

endmodule

// File: tb/tb_f2c_chunk_arbiter.sv
// Directed bench for f2c_chunk_arbiter: a chunk-level reference model is
// compared every cycle, plus hand-computed checkpoints for each scenario.
module tb_f2c_chunk_arbiter;
  localparam int NUM_SRC   = 2;
  localparam int CHUNK_QWS = 16;
  localparam int GW        = $clog2(NUM_SRC);

  logic                     pcieClk_in = 1'b0;
  logic                     pcieRstN_in;
  logic                     f2cReset_in;
  logic [GW-1:0]            grant_out;
  logic                     busy_out;
  logic [NUM_SRC-1:0][15:0] chunkCount_out;

  f2c_chunk_arbiter_if #(.NUM_SRC(NUM_SRC)) bus();

  f2c_chunk_arbiter #(.NUM_SRC(NUM_SRC), .CHUNK_QWS(CHUNK_QWS)) dut (
    .pcieClk_in     (pcieClk_in),
    .pcieRstN_in    (pcieRstN_in),
    .f2cReset_in    (f2cReset_in),
    .bus            (bus),
    .grant_out      (grant_out),
    .busy_out       (busy_out),
    .chunkCount_out (chunkCount_out)
  );

  always #5 pcieClk_in = ~pcieClk_in;

  int checks = 0;
  int errors = 0;
  int dutBeats;
  bit sawReady0;

  // Source i streams {i, 0, 1, 2, ...}, advancing only on its own handshake
  int seq[NUM_SRC];
  bit fire[NUM_SRC];

  // Chunk-level reference: who owns the port and how many QWs it has sent
  bit mBusy;
  int mGrant;
  int mDone;
  int mCount[NUM_SRC];
  int mSeq[NUM_SRC];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_SRC-1:0] valid, input logic ready, input logic f2cRst);
    bus.srcValid_in = valid;
    bus.f2cReady_in = ready;
    f2cReset_in     = f2cRst;
  endtask

  task automatic driveData();
    for (int i = 0; i < NUM_SRC; i++)
      bus.srcData_in[GW'(i)] = {8'(i), 56'(seq[i])};
  endtask

  task automatic modelReset();
    mBusy  = 1'b0;
    mGrant = NUM_SRC - 1;
    mDone  = 0;
    for (int i = 0; i < NUM_SRC; i++) mCount[i] = 0;
  endtask

  function automatic int pickNext(input int g, input logic [NUM_SRC-1:0] v);
    for (int k = 1; k <= NUM_SRC; k++)
      if (v[GW'((g + k) % NUM_SRC)]) return (g + k) % NUM_SRC;
    return g;
  endfunction

  task automatic modelCompare();
    logic [NUM_SRC-1:0] expReady;
    logic               expValid;
    logic [63:0]        expData;
    if (!pcieRstN_in) modelReset();
    for (int i = 0; i < NUM_SRC; i++)
      fire[i] = bus.srcValid_in[GW'(i)] && bus.srcReady_out[GW'(i)] && pcieRstN_in && !f2cReset_in;
    if (bus.f2cValid_out && bus.f2cReady_in && pcieRstN_in && !f2cReset_in) dutBeats++;
    sawReady0 = sawReady0 | bus.srcReady_out[0];
    expValid = mBusy && bus.srcValid_in[GW'(mGrant)];
    expData  = mBusy ? {8'(mGrant), 56'(mSeq[mGrant])} : 64'd0;
    for (int i = 0; i < NUM_SRC; i++)
      expReady[GW'(i)] = mBusy && (i == mGrant) && bus.f2cReady_in;
    checkOutput("busy", 64'(busy_out), 64'(mBusy));
    checkOutput("grant", 64'(grant_out), 64'(mGrant));
    checkOutput("f2cValid", 64'(bus.f2cValid_out), 64'(expValid));
    checkOutput("f2cData", bus.f2cData_out, expData);
    checkOutput("srcReady", 64'(bus.srcReady_out), 64'(expReady));
    for (int i = 0; i < NUM_SRC; i++)
      checkOutput("chunkCount", 64'(chunkCount_out[GW'(i)]), 64'(mCount[i]));
    if (!pcieRstN_in) return;
    if (f2cReset_in) begin
      modelReset();
    end else if (mBusy) begin
      if (expValid && bus.f2cReady_in) begin
        mSeq[mGrant]++;
        mDone++;
        if (mDone == CHUNK_QWS) begin
          mCount[mGrant] = (mCount[mGrant] + 1) % 65536;
          mBusy = 1'b0;
          mDone = 0;
        end
      end
    end else if (|bus.srcValid_in) begin
      mGrant = pickNext(mGrant, bus.srcValid_in);
      mBusy  = 1'b1;
    end
  endtask

  // One clock: compare on the falling edge, then land #1 after the rising edge
  task automatic cyc();
    @(negedge pcieClk_in);
    modelCompare();
    @(posedge pcieClk_in);
    #1;
    for (int i = 0; i < NUM_SRC; i++) if (fire[i]) seq[i]++;
    driveData();
  endtask

  initial begin
    for (int i = 0; i < NUM_SRC; i++) begin
      seq[i]  = 0;
      mSeq[i] = 0;
      fire[i] = 1'b0;
    end
    modelReset();
    dutBeats    = 0;
    sawReady0   = 1'b0;
    pcieRstN_in = 1'b0;
    applyStimulus('0, 1'b1, 1'b0);
    driveData();
    repeat (2) cyc();
    pcieRstN_in = 1'b1;
    $display("[TB] reset state");
    checkOutput("rst grant", 64'(grant_out), 64'd1);
    checkOutput("rst busy", 64'(busy_out), 64'd0);
    checkOutput("rst f2cValid", 64'(bus.f2cValid_out), 64'd0);
    checkOutput("rst counts", 64'(chunkCount_out), 64'd0);

    $display("[TB] two sources, ready held high");
    applyStimulus(2'b11, 1'b1, 1'b0);
    cyc();
    checkOutput("t2 busy@1", 64'(busy_out), 64'd1);
    checkOutput("t2 grant@1", 64'(grant_out), 64'd0);
    repeat (16) cyc();
    checkOutput("t2 idle@17", 64'(busy_out), 64'd0);
    checkOutput("t2 cnt0@17", 64'(chunkCount_out[0]), 64'd1);
    cyc();
    checkOutput("t2 grant@18", 64'(grant_out), 64'd1);
    repeat (16) cyc();
    checkOutput("t2 idle@34", 64'(busy_out), 64'd0);
    checkOutput("t2 counts@34", 64'(chunkCount_out), {32'd0, 16'd1, 16'd1});
    cyc();
    checkOutput("t2 grant@35", 64'(grant_out), 64'd0);
    checkOutput("t2 busy@35", 64'(busy_out), 64'd1);
    applyStimulus(2'b00, 1'b1, 1'b1);
    cyc();
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("t2 f2cReset busy", 64'(busy_out), 64'd0);
    checkOutput("t2 f2cReset grant", 64'(grant_out), 64'd1);
    checkOutput("t2 f2cReset counts", 64'(chunkCount_out), 64'd0);

    $display("[TB] lone source 1");
    sawReady0 = 1'b0;
    applyStimulus(2'b10, 1'b1, 1'b0);
    repeat (51) cyc();
    checkOutput("t3 cnt1", 64'(chunkCount_out[1]), 64'd3);
    checkOutput("t3 grant", 64'(grant_out), 64'd1);
    checkOutput("t3 ready0 never", 64'(sawReady0), 64'd0);
    applyStimulus(2'b00, 1'b1, 1'b0);

    $display("[TB] toggling ready");
    dutBeats = 0;
    begin
      bit done = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
        applyStimulus(2'b01, ((i % 2) == 0), 1'b0);
        cyc();
        if (i > 0 && !busy_out) done = 1'b1;
      end
      checkOutput("t4 chunk ended", 64'(done), 64'd1);
    end
    checkOutput("t4 beats", 64'(dutBeats), 64'd16);
    checkOutput("t4 cnt0", 64'(chunkCount_out[0]), 64'd1);
    checkOutput("t4 cnt1", 64'(chunkCount_out[1]), 64'd3);

    $display("[TB] stream reset mid-chunk");
    dutBeats = 0;
    applyStimulus(2'b01, 1'b1, 1'b0);
    repeat (8) cyc();
    checkOutput("t5 beats", 64'(dutBeats), 64'd7);
    applyStimulus(2'b01, 1'b1, 1'b1);
    cyc();
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("t5 busy", 64'(busy_out), 64'd0);
    checkOutput("t5 counts", 64'(chunkCount_out), 64'd0);
    cyc();
    checkOutput("t5 regrant", 64'(grant_out), 64'd0);
    checkOutput("t5 busy again", 64'(busy_out), 64'd1);

    $display("[TB] async reset mid-chunk");
    repeat (3) cyc();
    #1;
    pcieRstN_in = 1'b0;
    #1;
    checkOutput("t6 busy", 64'(busy_out), 64'd0);
    checkOutput("t6 f2cValid", 64'(bus.f2cValid_out), 64'd0);
    checkOutput("t6 counts", 64'(chunkCount_out), 64'd0);
    cyc();
    pcieRstN_in = 1'b1;

    $display("[TB] chunk counter wrap");
    cyc();
    cyc();
    force dut.chunkCountReg = {16'h0000, 16'hFFFF};
    mCount[0] = 16'hFFFF;
    #1;
    release dut.chunkCountReg;
    checkOutput("t7 preload", 64'(chunkCount_out[0]), 64'hFFFF);
    begin
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
        cyc();
        if (!busy_out) done = 1'b1;
      end
      checkOutput("t7 chunk ended", 64'(done), 64'd1);
    end
    checkOutput("t7 wrap", 64'(chunkCount_out[0]), 64'd0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/f2c_chunk_arbiter.md
F2C_CHUNK_ARBITER -- requirements
Module: f2c_chunk_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 2, number of FPGA->CPU stream requesters (legal 2..8).
REQ-002 Parameter CHUNK_QWS, default 16, QWs per chunk; a grant is held for exactly one chunk (legal 2..1024).
REQ-003 pcieClk_in  input  1  125MHz PCIe clock; sole clock.
REQ-004 pcieRstN_in  input  1  reset, asynchronous assert, active-low.
REQ-005 f2cReset_in  input  1  synchronous active-high DMA-stream reset from the TLP transceiver.
REQ-006 srcData_in  input  NUM_SRC x 64  per-source QW data.
REQ-007 srcValid_in  input  NUM_SRC  per-source valid.
REQ-008 srcReady_out  output  NUM_SRC  per-source ready.
REQ-009 f2cData_out  output  64  muxed QW to the transceiver f2c port.
REQ-010 f2cValid_out  output  1  muxed valid.
REQ-011 f2cReady_in  input  1  transceiver ready.
REQ-012 grant_out  output  clog2(NUM_SRC)  index of the source owning the current or most recent chunk.
REQ-013 busy_out  output  1  high while a chunk is in progress.
REQ-014 chunkCount_out  output  NUM_SRC x 16  completed chunks per source.

Function
REQ-015 A beat is a cycle with f2cValid_out=1 and f2cReady_in=1.
REQ-016 The FSM has states S_IDLE and S_BUSY only.
REQ-017 In S_IDLE: all srcReady_out=0, f2cValid_out=0, f2cData_out=0, busy_out=0.
REQ-018 In S_IDLE with any srcValid_in high: select the first requesting index strictly after grant_out, in increasing order modulo NUM_SRC; register it into grant_out; load qwCount=CHUNK_QWS-1; go to S_BUSY next cycle.
REQ-019 Arbitration latency: exactly one cycle from srcValid_in rising in S_IDLE to f2cValid_out able to rise.
REQ-020 In S_BUSY: f2cData_out=srcData_in[grant]; f2cValid_out=srcValid_in[grant]; srcReady_out[grant]=f2cReady_in; every other srcReady_out=0; busy_out=1.
REQ-021 In S_BUSY, requests from other sources are ignored until the chunk ends; a granted source dropping valid mid-chunk stalls the stream without losing the grant.
REQ-022 Each beat with qwCount>0 decrements qwCount by 1.
REQ-023 The beat with qwCount=0 increments chunkCount_out[grant] (16-bit wrap, 0xFFFF->0x0000) and returns to S_IDLE; grant_out holds its value.
REQ-024 No re-arbitration occurs on the last beat; the next chunk cannot start earlier than the cycle after return to S_IDLE (one idle cycle between chunks).
REQ-025 A source requesting alone is re-granted on every arbitration.
REQ-026 Data, valid and ready paths are combinational through the mux; no buffering, so QW order and content per source are preserved exactly.

Reset
REQ-027 pcieRstN_in low: immediately state=S_IDLE, grant_out=NUM_SRC-1 (so source 0 wins first), qwCount=0, all chunkCount_out=0; outputs as REQ-017.
REQ-028 f2cReset_in high at a clock edge: same values as REQ-027 on that edge, including mid-chunk (partial chunk abandoned, not counted).
REQ-029 f2cReset_in takes priority over any simultaneous beat or arbitration.

Verification
REQ-030 After reset, src0 and src1 both valid, f2cReady_in=1, CHUNK_QWS=16 -> grant 0 for 16 beats, 1 idle cycle, grant 1 for 16 beats, then grant 0; chunkCount = 1,1 after 33 beats+idles.
REQ-031 Only src1 valid, 3 chunks -> grant_out=1 every chunk, chunkCount_out[1]=3, srcReady_out[0]=0 throughout.
REQ-032 f2cReady_in toggled 1010... during a chunk -> exactly 16 beats delivered, data order matches src stream, srcReady_out[grant] mirrors f2cReady_in.
REQ-033 f2cReset_in pulsed after 7 beats of src0 chunk -> next cycle S_IDLE, chunkCount_out[0]=0, next grant is src0.
REQ-034 pcieRstN_in asserted asynchronously mid-chunk -> busy_out and f2cValid_out fall without a clock edge; all counters 0.
REQ-035 Preload 0xFFFF completed chunks on src0 (force or long run) and finish one more -> chunkCount_out[0]=0x0000.
